intersection_controller: RTL and testbench

Sequencing controller for a two-way signalised intersection with one pedestrian crossing. It advances a phase state machine on half-second ticks and emits the 3-bit light codes that the per-head seven-segment light drivers decode: north-south vehicle head, east-west vehicle head and walk head. It sits between the half-second timebase and the three light-driver instances.

---
 rtl/traffic_pkg.sv | 31 +++
 rtl/phase_timer.sv | 27 ++
 rtl/intersection_controller.sv | 165 ++++++++++++++++
 tb/tb_intersection_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Light codes and phase/walk state encodings shared by the controller and the light drivers.
// NS_LEFT exists only when ADVANCED_LEFT_EN is defined.
package traffic_pkg;

  localparam logic [2:0] LIGHT_GREEN     = 3'b001;
  localparam logic [2:0] LIGHT_AMBER     = 3'b010;
  localparam logic [2:0] LIGHT_RED       = 3'b100;
  localparam logic [2:0] LIGHT_LEFT      = 3'b101;
  localparam logic [2:0] LIGHT_WALK      = 3'b110;
  localparam logic [2:0] LIGHT_DONT_WALK = 3'b011;
  localparam logic [2:0] LIGHT_FLASH_DW  = 3'b111;

  typedef enum logic [2:0] {
    ALL_RED_A = 3'd0,
`ifdef ADVANCED_LEFT_EN
    NS_LEFT   = 3'd1,
`endif
    NS_GREEN  = 3'd2,
    NS_AMBER  = 3'd3,
    ALL_RED_B = 3'd4,
    EW_GREEN  = 3'd5,
    EW_AMBER  = 3'd6
  } phase_t;

  typedef enum logic [1:0] {
    WALK_IDLE  = 2'd0,
    WALK_ON    = 2'd1,
    WALK_FLASH = 2'd2
  } walk_t;

endpackage

// File: rtl/phase_timer.sv
// 8-bit loadable down-counter; done flags a tick arriving while the count is already zero.
module phase_timer #(
  parameter logic [7:0] RESET_VALUE = 8'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       tick,
  input  logic [7:0] load_value,
  output logic       done
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (tick && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign done = tick && (count == 8'd0);

endmodule

// File: rtl/intersection_controller.sv
// Two-way intersection phase sequencer with pedestrian walk sequence on half-second ticks.
// Optional advanced north-south left arrow compiled in with ADVANCED_LEFT_EN.
module intersection_controller
  import traffic_pkg::*;
#(
  parameter int GREEN_TICKS  = 20,
  parameter int AMBER_TICKS  = 6,
  parameter int ALLRED_TICKS = 2,
  parameter int LEFT_TICKS   = 8,
  parameter int WALK_TICKS   = 8,
  parameter int FLASH_TICKS  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       halfSec,
  input  logic       pedRequest,
  input  logic       leftRequest,
  output logic [2:0] nsLight,
  output logic [2:0] ewLight,
  output logic [2:0] walkLight
);

  phase_t     state, state_next;
  walk_t      walk, walk_next;
  logic       phase_done, walk_done, walk_load;
  logic [7:0] phase_load_value, walk_load_value;
  logic       ped_pending, left_pending, ns_green_entry;

  function automatic logic [7:0] dur_m1(input phase_t p);
    case (p)
`ifdef ADVANCED_LEFT_EN
      NS_LEFT:            dur_m1 = 8'(LEFT_TICKS - 1);
`endif
      NS_GREEN, EW_GREEN: dur_m1 = 8'(GREEN_TICKS - 1);
      NS_AMBER, EW_AMBER: dur_m1 = 8'(AMBER_TICKS - 1);
      default:            dur_m1 = 8'(ALLRED_TICKS - 1);
    endcase
  endfunction

  phase_timer #(.RESET_VALUE(8'(ALLRED_TICKS - 1))) u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (phase_done),
    .tick       (halfSec),
    .load_value (phase_load_value),
    .done       (phase_done)
  );

  phase_timer #(.RESET_VALUE(8'd0)) u_walk_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (walk_load),
    .tick       (halfSec),
    .load_value (walk_load_value),
    .done       (walk_done)
  );

  always_comb begin
    state_next = state;
    if (phase_done) begin
      case (state)
`ifdef ADVANCED_LEFT_EN
        ALL_RED_A: state_next = left_pending ? NS_LEFT : NS_GREEN;
        NS_LEFT:   state_next = NS_GREEN;
`else
        ALL_RED_A: state_next = NS_GREEN;
`endif
        NS_GREEN:  state_next = NS_AMBER;
        NS_AMBER:  state_next = ALL_RED_B;
        ALL_RED_B: state_next = EW_GREEN;
        EW_GREEN:  state_next = EW_AMBER;
        EW_AMBER:  state_next = ALL_RED_A;
        default:   state_next = ALL_RED_A;
      endcase
    end
  end

  assign phase_load_value = dur_m1(state_next);
  assign ns_green_entry   = phase_done && (state_next == NS_GREEN);

  // Starting a walk on green entry takes priority over the walk timer's own steps.
  always_comb begin
    walk_next       = walk;
    walk_load       = 1'b0;
    walk_load_value = 8'(WALK_TICKS - 1);
    if (ns_green_entry && ped_pending) begin
      walk_next = WALK_ON;
      walk_load = 1'b1;
    end else if (walk_done) begin
      case (walk)
        WALK_ON: begin
          walk_next       = WALK_FLASH;
          walk_load       = 1'b1;
          walk_load_value = 8'(FLASH_TICKS - 1);
        end
        WALK_FLASH: walk_next = WALK_IDLE;
        default:    walk_next = WALK_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ALL_RED_A;
      walk  <= WALK_IDLE;
    end else begin
      state <= state_next;
      walk  <= walk_next;
    end
  end

  // A new request on the clearing clock keeps the latch set.
  always_ff @(posedge clk) begin
    if (reset) begin
      ped_pending <= 1'b0;
    end else if (pedRequest) begin
      ped_pending <= 1'b1;
    end else if (ns_green_entry) begin
      ped_pending <= 1'b0;
    end
  end

`ifdef ADVANCED_LEFT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      left_pending <= 1'b0;
    end else if (leftRequest) begin
      left_pending <= 1'b1;
    end else if (phase_done && (state_next == NS_LEFT)) begin
      left_pending <= 1'b0;
    end
  end
`else
  logic unused_left;
  assign left_pending = 1'b0;
  assign unused_left  = leftRequest | (LEFT_TICKS != 0) | left_pending;
`endif

  always_comb begin
    nsLight = LIGHT_RED;
    ewLight = LIGHT_RED;
    case (state)
`ifdef ADVANCED_LEFT_EN
      NS_LEFT:  nsLight = LIGHT_LEFT;
`endif
      NS_GREEN: nsLight = LIGHT_GREEN;
      NS_AMBER: nsLight = LIGHT_AMBER;
      EW_GREEN: ewLight = LIGHT_GREEN;
      EW_AMBER: ewLight = LIGHT_AMBER;
      default: begin
        nsLight = LIGHT_RED;
        ewLight = LIGHT_RED;
      end
    endcase
  end

  always_comb begin
    case (walk)
      WALK_ON:    walkLight = LIGHT_WALK;
      WALK_FLASH: walkLight = LIGHT_FLASH_DW;
      default:    walkLight = LIGHT_DONT_WALK;
    endcase
  end

endmodule

// File: tb/tb_intersection_controller.sv
// Scoreboard bench for intersection_controller: a cycle model pushes expected lights per driven cycle.
// Scenario checks adapt to ADVANCED_LEFT_EN.
module tb_intersection_controller;

  localparam int G = 4, A = 2, R = 1, L = 2, W = 2, F = 1;
`ifdef ADVANCED_LEFT_EN
  localparam bit LEFT_EN = 1'b1;
`else
  localparam bit LEFT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, halfSec, pedRequest, leftRequest;
  logic [2:0] nsLight, ewLight, walkLight;

  intersection_controller #(
    .GREEN_TICKS (G), .AMBER_TICKS (A), .ALLRED_TICKS(R),
    .LEFT_TICKS  (L), .WALK_TICKS  (W), .FLASH_TICKS (F)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .halfSec     (halfSec),
    .pedRequest  (pedRequest),
    .leftRequest (leftRequest),
    .nsLight     (nsLight),
    .ewLight     (ewLight),
    .walkLight   (walkLight)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [8:0] exp_q[$];

  // model: phases 0 ARA,1 LEFT,2 NSG,3 NSA,4 ARB,5 EWG,6 EWA; walk 0 idle,1 on,2 flash
  int m_ph, m_rem, m_walk, m_wrem;
  bit m_ped, m_left;
  int n_left, n_walk, n_flash, n_nsg, n_ewg;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dur(input int p);
    case (p)
      1:       return L;
      2, 5:    return G;
      3, 6:    return A;
      default: return R;
    endcase
  endfunction

  function automatic int nxt(input int p);
    if (p == 0) return (LEFT_EN && m_left) ? 1 : 2;
    if (p == 6) return 0;
    return p + 1;
  endfunction

  function automatic logic [8:0] model_out();
    logic [2:0] ns, ew, wk;
    ns = 3'b100; ew = 3'b100;
    case (m_ph)
      1: ns = 3'b101;
      2: ns = 3'b001;
      3: ns = 3'b010;
      5: ew = 3'b001;
      6: ew = 3'b010;
      default: ;
    endcase
    wk = (m_walk == 1) ? 3'b110 : (m_walk == 2) ? 3'b111 : 3'b011;
    return {ns, ew, wk};
  endfunction

  task automatic model_edge(input bit r, input bit hs, input bit ped, input bit left);
    bit np, nl;
    int p;
    if (r) begin
      m_ph = 0; m_rem = R - 1; m_ped = 0; m_left = 0; m_walk = 0; m_wrem = 0;
    end else begin
      np = m_ped; nl = m_left;
      if (hs) begin
        if (m_walk != 0) begin
          if (m_wrem == 0) begin
            if (m_walk == 1) begin m_walk = 2; m_wrem = F - 1; end
            else m_walk = 0;
          end else m_wrem--;
        end
        if (m_rem == 0) begin
          p = nxt(m_ph);
          if (p == 2 && m_ped) begin np = 0; m_walk = 1; m_wrem = W - 1; end
          if (p == 1) nl = 0;
          m_ph = p;
          m_rem = dur(p) - 1;
        end else m_rem--;
      end
      if (ped) np = 1;
      if (left && LEFT_EN) nl = 1;
      m_ped = np; m_left = nl;
    end
  endtask

  task automatic clear_counts();
    n_left = 0; n_walk = 0; n_flash = 0; n_nsg = 0; n_ewg = 0;
  endtask

  task automatic step(input bit r, input bit hs, input bit ped, input bit left);
    logic [8:0] obs;
    @(negedge clk);
    reset = r; halfSec = hs; pedRequest = ped; leftRequest = left;
    model_edge(r, hs, ped, left);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    obs = {nsLight, ewLight, walkLight};
    check_eq("scoreboard", int'(obs), int'(exp_q.pop_front()));
    if (nsLight == 3'b101) n_left++;
    if (nsLight == 3'b001) n_nsg++;
    if (ewLight == 3'b001) n_ewg++;
    if (walkLight == 3'b110) n_walk++;
    if (walkLight == 3'b111) n_flash++;
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 64 && m_ph != p; i++) step(0, 1, 0, 0);
    if (m_ph != p) check_eq("wait_phase_timeout", m_ph, p);
  endtask

  logic [5:0] seq1 [14];

  initial begin
    reset = 1'b1; halfSec = 1'b0; pedRequest = 1'b0; leftRequest = 1'b0;
    seq1 = '{6'b001100, 6'b001100, 6'b001100, 6'b001100, 6'b010100, 6'b010100,
             6'b100100, 6'b100001, 6'b100001, 6'b100001, 6'b100001,
             6'b100010, 6'b100010, 6'b100100};
    clear_counts();

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check_eq("reset_out", int'({nsLight, ewLight, walkLight}), int'(9'b100_100_011));

    for (int i = 0; i < 14; i++) begin
      step(0, 1, 0, 0);
      check_eq("base_seq", int'({nsLight, ewLight}), int'(seq1[i]));
    end

    // pedestrian request during EW green
    wait_phase(5);
    step(0, 1, 1, 0);
    clear_counts();
    repeat (20) step(0, 1, 0, 0);
    check_eq("ped_ew_walk", n_walk, 2);
    check_eq("ped_ew_flash", n_flash, 1);

    // pedestrian request on the second NS green tick
    wait_phase(2);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    clear_counts();
    repeat (6) step(0, 1, 0, 0);
    check_eq("late_ped_held", n_walk, 0);
    clear_counts();
    repeat (14) step(0, 1, 0, 0);
    check_eq("late_ped_next", n_walk, 2);

    // left-turn request during EW amber
    wait_phase(6);
    step(0, 1, 0, 1);
    clear_counts();
    repeat (16) step(0, 1, 0, 0);
    check_eq("left_arrow", n_left, LEFT_EN ? 2 : 0);
    clear_counts();
    repeat (16) step(0, 1, 0, 0);
    check_eq("left_skip", n_left, 0);

    // reset during NS amber with both requests pending
    wait_phase(3);
    step(0, 1, 1, 1);
    step(1, 1, 0, 0);
    check_eq("midreset_out", int'({nsLight, ewLight, walkLight}), int'(9'b100_100_011));
    clear_counts();
    repeat (10) step(0, 1, 0, 0);
    check_eq("midreset_ped_clr", n_walk, 0);
    check_eq("midreset_left_clr", n_left, 0);

    // half-second every third clock, ped request on the NS green entry clock
    step(1, 0, 0, 0);
    clear_counts();
    for (int k = 0; k < 42; k++) step(0, (k % 3) == 2, k == 2, 0);
    check_eq("slow_ns_green", n_nsg, 3 * G);
    check_eq("slow_ew_green", n_ewg, 3 * G);
    check_eq("slow_entry_nowalk", n_walk, 0);
    clear_counts();
    for (int k = 42; k < 84; k++) step(0, (k % 3) == 2, 0, 0);
    check_eq("slow_walk", n_walk, 3 * W);
    check_eq("slow_flash", n_flash, 3 * F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
